// File: rtl/uart_rx_word.sv
// 8N1 UART receiver that assembles DATA_WIDTH/8 bytes, low byte first, into one word.
// Partial words are dropped after an inter-byte idle timeout or a framing error.
`timescale 1ns/1ps
module uart_rx_word #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned CLOCK_PER_BIT = 1000,
    parameter int unsigned TIMEOUT_BITS  = 16
) (
    input  logic                  clk,
    input  logic                  a_reset_n,
    input  logic                  uart_in,
    output logic                  data_valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  frame_error,
    output logic                  busy
);

    localparam int unsigned NBYTES    = DATA_WIDTH / 8;
    localparam int unsigned CNT_W     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int unsigned TMR_W     = $clog2(CLOCK_PER_BIT) + 1;
    localparam int unsigned TO_CYCLES = TIMEOUT_BITS * CLOCK_PER_BIT;
    localparam int unsigned TO_W      = $clog2(TO_CYCLES) + 1;

    localparam logic [TMR_W-1:0] HALF_LAST = TMR_W'(CLOCK_PER_BIT / 2 - 1);
    localparam logic [TMR_W-1:0] FULL_LAST = TMR_W'(CLOCK_PER_BIT - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_e;

    state_e                state_q, state_d;
    logic                  sync1_q, sync2_q, prev_q;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic [2:0]            bitn_q, bitn_d;
    logic [7:0]            shift_q, shift_d;
    logic [CNT_W-1:0]      byte_cnt_q, byte_cnt_d;
    logic [DATA_WIDTH-1:0] asm_q, asm_d;
    logic [TO_W-1:0]       idle_tmr_q, idle_tmr_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  valid_q, valid_d;
    logic                  ferr_q, ferr_d;
    logic [DATA_WIDTH-1:0] word_c;
    logic                  rx;
    logic                  fall;

    assign rx   = sync2_q;
    assign fall = prev_q & ~sync2_q;

    always_ff @(posedge clk) begin
        if (!a_reset_n) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            state_q    <= IDLE;
            timer_q    <= '0;
            bitn_q     <= '0;
            shift_q    <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            idle_tmr_q <= '0;
            dout_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            sync1_q    <= uart_in;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            state_q    <= state_d;
            timer_q    <= timer_d;
            bitn_q     <= bitn_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            idle_tmr_q <= idle_tmr_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
        end
    end

    // Assembly register with the just-received byte dropped into its slot.
    always_comb begin
        word_c = asm_q;
        for (int unsigned k = 0; k < NBYTES; k++) begin
            if (byte_cnt_q == CNT_W'(k)) begin
                word_c[8*k +: 8] = shift_q;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q + TMR_W'(1);
        bitn_d     = bitn_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        idle_tmr_d = '0;
        dout_d     = dout_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (byte_cnt_q != '0) begin
                    if (idle_tmr_q == TO_LAST) begin
                        byte_cnt_d = '0;
                        asm_d      = '0;
                    end else begin
                        idle_tmr_d = idle_tmr_q + TO_W'(1);
                    end
                end
                if (fall) begin
                    state_d = START;
                end
            end

            START: begin
                if (timer_q == HALF_LAST) begin
                    timer_d = '0;
                    if (!rx) begin
                        state_d = DATA;
                        bitn_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            DATA: begin
                if (timer_q == FULL_LAST) begin
                    timer_d = '0;
                    shift_d = {rx, shift_q[7:1]};
                    if (bitn_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bitn_d = bitn_q + 3'd1;
                    end
                end
            end

            // Returning to IDLE at the mid-stop sample leaves half a bit to catch
            // the next start edge of a back-to-back frame.
            STOP: begin
                if (timer_q == FULL_LAST) begin
                    timer_d = '0;
                    if (rx) begin
                        state_d = IDLE;
                        if (byte_cnt_q == LAST_BYTE) begin
                            byte_cnt_d = '0;
                            asm_d      = '0;
                            dout_d     = word_c;
                            valid_d    = 1'b1;
                        end else begin
                            byte_cnt_d = byte_cnt_q + CNT_W'(1);
                            asm_d      = word_c;
                        end
                    end else begin
                        state_d    = WAIT_HIGH;
                        byte_cnt_d = '0;
                        asm_d      = '0;
                        ferr_d     = 1'b1;
                    end
                end
            end

            WAIT_HIGH: begin
                timer_d = '0;
                if (rx) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    assign data_valid  = valid_q;
    assign frame_error = ferr_q;
    assign data_out    = dout_q;
    assign busy        = (state_q != IDLE) || (byte_cnt_q != '0);

endmodule

// File: tb/tb_uart_rx_word.sv
// Bench for uart_rx_word: directed vector table, hand-written corner sequences and
// randomized frame streams checked against a byte-list reference model.
`timescale 1ns/1ps
module tb_uart_rx_word;

    localparam int CPB = 16;
    localparam int DW  = 16;
    localparam int TOB = 16;
    localparam int TAIL = TOB * CPB + 100;

    logic          clk = 1'b0;
    logic          a_reset_n;
    logic          uart_in;
    logic          data_valid;
    logic [DW-1:0] data_out;
    logic          frame_error;
    logic          busy;

    always #5 clk = ~clk;

    uart_rx_word #(
        .DATA_WIDTH   (DW),
        .CLOCK_PER_BIT(CPB),
        .TIMEOUT_BITS (TOB)
    ) dut (
        .clk        (clk),
        .a_reset_n  (a_reset_n),
        .uart_in    (uart_in),
        .data_valid (data_valid),
        .data_out   (data_out),
        .frame_error(frame_error),
        .busy       (busy)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] got_q[$];
    int            fe_seen = 0;
    bit            both_seen = 1'b0;

    always @(negedge clk) begin
        if (a_reset_n === 1'b1) begin
            if (data_valid === 1'b1) got_q.push_back(data_out);
            if (frame_error === 1'b1) fe_seen++;
            if (data_valid === 1'b1 && frame_error === 1'b1) both_seen = 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  data;
        bit          stop_ok;
        int unsigned low_hold;
        int unsigned gap;
    } frame_t;

    frame_t        frames[$];
    logic [DW-1:0] exp_q[$];
    int            exp_fe;
    logic [DW-1:0] last_word = '0;
    int            got_base;
    int            fe_base;

    function automatic frame_t mk(input logic [7:0] d, input bit ok,
                                  input int unsigned hold, input int unsigned gap);
        frame_t f;
        f.data = d; f.stop_ok = ok; f.low_hold = hold; f.gap = gap;
        return f;
    endfunction

    task automatic send_bit(input logic b);
        uart_in = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input frame_t f);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(f.data[i]);
        send_bit(f.stop_ok);
        if (!f.stop_ok) begin
            uart_in = 1'b0;
            repeat (f.low_hold) @(negedge clk);
        end
        uart_in = 1'b1;
    endtask

    // Sends the queued frames with their gaps, then a tail long enough to time out any partial word.
    task automatic play();
        got_base = got_q.size();
        fe_base  = fe_seen;
        foreach (frames[i]) begin
            send_frame(frames[i]);
            repeat (frames[i].gap) @(negedge clk);
        end
        repeat (TAIL) @(negedge clk);
    endtask

    // Reference: bytes collect into a list; two good bytes make a word, a bad stop
    // empties the list, and an idle stretch past the timeout empties it too.
    task automatic run_model();
        logic [7:0] part[$];
        exp_q.delete();
        exp_fe = 0;
        foreach (frames[i]) begin
            if (!frames[i].stop_ok) begin
                exp_fe++;
                part.delete();
            end else begin
                part.push_back(frames[i].data);
                if (part.size() == DW / 8) begin
                    exp_q.push_back({part[1], part[0]});
                    part.delete();
                end
            end
            if (frames[i].gap + CPB / 2 >= TOB * CPB) part.delete();
        end
    endtask

    task automatic compare(input string tag);
        int n;
        n = got_q.size() - got_base;
        check({tag, "_nwords"}, n, exp_q.size());
        foreach (exp_q[i]) begin
            if (i < n) check($sformatf("%s_word%0d", tag, i), got_q[got_base + i], exp_q[i]);
        end
        check({tag, "_nframe_err"}, fe_seen - fe_base, exp_fe);
        check({tag, "_busy_end"}, busy, 1'b0);
        if (exp_q.size() > 0) last_word = exp_q[exp_q.size() - 1];
        check({tag, "_data_out_held"}, data_out, last_word);
        check({tag, "_no_overlap"}, both_seen, 1'b0);
    endtask

    typedef struct {
        logic [7:0]    b0;
        bit            ok0;
        int unsigned   hold0;
        int unsigned   gap0;
        logic [7:0]    b1;
        int unsigned   exp_n;
        logic [DW-1:0] exp_word;
        int unsigned   exp_fe;
    } vec_t;

    function automatic vec_t mkv(input logic [7:0] b0, input bit ok0, input int unsigned hold0,
                                 input int unsigned gap0, input logic [7:0] b1,
                                 input int unsigned n, input logic [DW-1:0] w, input int unsigned fe);
        vec_t v;
        v.b0 = b0; v.ok0 = ok0; v.hold0 = hold0; v.gap0 = gap0; v.b1 = b1;
        v.exp_n = n; v.exp_word = w; v.exp_fe = fe;
        return v;
    endfunction

    vec_t vecs[6];

    initial begin
        vecs[0] = mkv(8'h34, 1'b1, 0,  0,   8'h12, 1, 16'h1234, 0);
        vecs[1] = mkv(8'hEF, 1'b1, 0,  50,  8'hBE, 1, 16'hBEEF, 0);
        vecs[2] = mkv(8'h00, 1'b1, 0,  200, 8'hFF, 1, 16'hFF00, 0);
        vecs[3] = mkv(8'h55, 1'b1, 0,  300, 8'hAA, 0, 16'h0000, 0);
        vecs[4] = mkv(8'h77, 1'b0, 40, 16,  8'hCD, 0, 16'h0000, 1);
        vecs[5] = mkv(8'hFF, 1'b1, 0,  0,   8'h00, 1, 16'h00FF, 0);

        a_reset_n = 1'b0;
        uart_in   = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_data_out", data_out, '0);
        check("rst_data_valid", data_valid, 1'b0);
        check("rst_frame_error", frame_error, 1'b0);
        check("rst_busy", busy, 1'b0);
        a_reset_n = 1'b1;
        repeat (10) @(negedge clk);

        foreach (vecs[i]) begin
            frames.delete();
            frames.push_back(mk(vecs[i].b0, vecs[i].ok0, vecs[i].hold0, vecs[i].gap0));
            frames.push_back(mk(vecs[i].b1, 1'b1, 0, 0));
            play();
            check($sformatf("vec%0d_nwords", i), got_q.size() - got_base, vecs[i].exp_n);
            if (vecs[i].exp_n == 1 && got_q.size() > got_base) begin
                check($sformatf("vec%0d_word", i), got_q[got_base], vecs[i].exp_word);
                last_word = vecs[i].exp_word;
            end
            check($sformatf("vec%0d_nframe_err", i), fe_seen - fe_base, vecs[i].exp_fe);
            check($sformatf("vec%0d_data_out", i), data_out, last_word);
        end

        // Short low glitch must be rejected as a false start.
        got_base = got_q.size();
        fe_base  = fe_seen;
        uart_in = 1'b0;
        repeat (3) @(negedge clk);
        uart_in = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_nwords", got_q.size() - got_base, 0);
        check("glitch_nframe_err", fe_seen - fe_base, 0);
        check("glitch_idle", busy, 1'b0);
        frames.delete();
        frames.push_back(mk(8'hEF, 1'b1, 0, 0));
        frames.push_back(mk(8'hBE, 1'b1, 0, 0));
        run_model();
        play();
        compare("after_glitch");

        // Bad stop held low, then a good word.
        frames.delete();
        frames.push_back(mk(8'h77, 1'b0, 40, 16));
        frames.push_back(mk(8'hCD, 1'b1, 0, 0));
        frames.push_back(mk(8'hAB, 1'b1, 0, 0));
        run_model();
        play();
        compare("bad_stop");
        check("bad_stop_expect_abcd", last_word, 16'hABCD);

        // Lone byte times out; busy observed either side of the timeout.
        got_base = got_q.size();
        fe_base  = fe_seen;
        send_frame(mk(8'h55, 1'b1, 0, 0));
        repeat (20) @(negedge clk);
        check("partial_busy", busy, 1'b1);
        repeat (280) @(negedge clk);
        check("timeout_busy_clear", busy, 1'b0);
        send_frame(mk(8'hAA, 1'b1, 0, 0));
        send_frame(mk(8'h0F, 1'b1, 0, 0));
        repeat (TAIL) @(negedge clk);
        check("timeout_nwords", got_q.size() - got_base, 1);
        if (got_q.size() > got_base) check("timeout_word", got_q[got_base], 16'h0FAA);
        last_word = 16'h0FAA;

        // Reset in the middle of data bit 4.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i == 0);
        repeat (CPB / 2) @(negedge clk);
        a_reset_n = 1'b0;
        uart_in   = 1'b1;
        repeat (4) @(negedge clk);
        check("midrst_data_out", data_out, '0);
        check("midrst_data_valid", data_valid, 1'b0);
        check("midrst_frame_error", frame_error, 1'b0);
        check("midrst_busy", busy, 1'b0);
        a_reset_n = 1'b1;
        last_word = '0;
        repeat (20) @(negedge clk);
        frames.delete();
        frames.push_back(mk(8'h01, 1'b1, 0, 0));
        frames.push_back(mk(8'h80, 1'b1, 0, 0));
        run_model();
        play();
        compare("after_reset");

        // Six back-to-back frames with no idle bits.
        frames.delete();
        frames.push_back(mk(8'h34, 1'b1, 0, 0));
        frames.push_back(mk(8'h12, 1'b1, 0, 0));
        frames.push_back(mk(8'h78, 1'b1, 0, 0));
        frames.push_back(mk(8'h56, 1'b1, 0, 0));
        frames.push_back(mk(8'hBC, 1'b1, 0, 0));
        frames.push_back(mk(8'h9A, 1'b1, 0, 0));
        run_model();
        play();
        compare("b2b");

        // Random streams; gaps avoid the band around the timeout threshold.
        for (int r = 0; r < 5; r++) begin
            frames.delete();
            for (int i = 0; i < 9; i++) begin
                frame_t f;
                f.data     = 8'($urandom);
                f.stop_ok  = ($urandom_range(0, 5) != 0);
                f.low_hold = f.stop_ok ? 0 : $urandom_range(0, 40);
                if (!f.stop_ok)                    f.gap = $urandom_range(16, 60);
                else if ($urandom_range(0, 3) == 0) f.gap = $urandom_range(300, 400);
                else                                f.gap = $urandom_range(0, 150);
                frames.push_back(f);
            end
            run_model();
            play();
            compare($sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_word.md
UART_RX_WORD -- requirements
Module: uart_rx_word

Interface
REQ-001 Parameter DATA_WIDTH, default 16: received word width; SHALL be a multiple of 8 and at least 8.
REQ-002 Parameter CLOCK_PER_BIT, default 1000: clk cycles per UART bit; SHALL be at least 8.
REQ-003 Parameter TIMEOUT_BITS, default 16: maximum idle gap between bytes of one word, in bit periods.
REQ-004 Port clk  input  1: single clock; all logic SHALL be clocked on the rising edge of clk.
REQ-005 Port a_reset_n  input  1: reset; synchronous, active-low.
REQ-006 Port uart_in  input  1: asynchronous serial line, idle high.
REQ-007 Port data_valid  output  1: one-cycle pulse when a complete word is presented on data_out.
REQ-008 Port data_out  output  DATA_WIDTH: last complete received word.
REQ-009 Port frame_error  output  1: one-cycle pulse when a stop bit is sampled low.
REQ-010 Port busy  output  1: high whenever the FSM is not in IDLE or a partial word is held.

Function
REQ-011 Framing SHALL be 8N1: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
REQ-012 Word assembly SHALL be low byte first: byte k fills data_out[8k+7:8k], for k = 0 .. DATA_WIDTH/8-1.
REQ-013 uart_in SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value.
REQ-014 The FSM SHALL have the states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-015 IDLE -> START on a synchronized falling edge (previous 1, current 0).
REQ-016 START: after CLOCK_PER_BIT/2 cycles, sample the line: 0 -> DATA with the bit timer cleared; 1 -> IDLE (false start, no pulse, byte counter unchanged).
REQ-017 DATA: sample every CLOCK_PER_BIT cycles, 8 samples into the shift register LSB first, then -> STOP.
REQ-018 STOP: sample after CLOCK_PER_BIT cycles. Line 1: commit the byte. Line 0: pulse frame_error, discard the byte and the partial word, clear the byte counter, -> WAIT_HIGH.
REQ-019 WAIT_HIGH -> IDLE when the synchronized line is 1 (break tolerance).
REQ-020 Byte commit: write the byte into its slot and increment the byte counter. If this is the last byte, the counter SHALL wrap to 0, the whole word SHALL update data_out, and data_valid SHALL pulse on the cycle after the stop sample. The FSM then -> IDLE.
REQ-021 data_out SHALL change only on word completion; partial bytes SHALL be held in a separate assembly register.
REQ-022 Inter-byte timeout: while the byte counter != 0 and the FSM is in IDLE, count cycles. At TIMEOUT_BITS*CLOCK_PER_BIT cycles, clear the counter and discard the partial word; frame_error SHALL NOT pulse.
REQ-023 A falling edge during STOP after a valid stop sample SHALL NOT be missed: back-to-back frames with zero idle bits SHALL be received.
REQ-024 data_valid and frame_error SHALL never be high in the same cycle.

Reset
REQ-025 On clk with a_reset_n=0: FSM=IDLE, byte counter=0, timers=0, shift and assembly registers=0, data_out=0, data_valid=0, frame_error=0, busy=0; the synchronizer flops SHALL be set to 1.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no pulse; the first complete frame after release SHALL be received correctly.

Verification (CLOCK_PER_BIT=16, DATA_WIDTH=16, TIMEOUT_BITS=16)
REQ-027 Send bytes 0x34 then 0x12 -> a single data_valid pulse, data_out=0x1234, frame_error never high.
REQ-028 Drive uart_in low for 3 clk, then high -> no data_valid, no frame_error, FSM back in IDLE, next word 0xBEEF received as 0xBEEF.
REQ-029 Send 0x77 with stop bit 0, hold low for 40 clk, then send 0xCD, 0xAB -> one frame_error pulse, then data_valid with data_out=0xABCD.
REQ-030 Send 0x55, idle 300 clk, then send 0xAA, 0x0F -> no data_valid after 0x55 alone, then data_valid with data_out=0x0FAA.
REQ-031 Assert reset during bit 4 of the first byte, release, send 0x01, 0x80 -> outputs 0 during reset, then data_valid with data_out=0x8001.
REQ-032 Send the words 0x1234, 0x5678, 0x9ABC as 6 back-to-back frames with no idle -> 3 data_valid pulses carrying those values in order.
